// File: rtl/arv_store_buffer.sv
// arv_store_buffer: posted-write store FIFO in front of a single-port SRAM.
// Loads own the port and see byte-granular forwarding from buffered stores.
// Stores drain whenever the core is not loading. The core is never stalled.
module arv_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write,
  input  logic [31:0] write_address,
  input  logic [31:0] DATA_out,
  input  logic [1:0]  size,
  input  logic        read,
  input  logic [31:0] read_address,
  output logic [31:0] DATA_in,
  output logic        mem_en,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        empty,
  output logic        full,
  output logic        overflow,
  output logic        misalign
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } entry_t;

  entry_t        ent_q [DEPTH];
  entry_t        ent_d [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          misalign_q, misalign_d;
  logic [3:0]    fwd_mask_q, fwd_mask_d;
  logic [31:0]   fwd_data_q, fwd_data_d;
  logic          rd_pend_q, rd_pend_d;
  logic [31:0]   data_in_q, data_in_d;

  entry_t        st;
  logic          st_ok;
  logic          pop, push;
  logic [31:0]   merged;
  logic [PW-1:0] idx;

  // Low address bits of a load are irrelevant: the whole word is returned.
  logic unused_ok;
  assign unused_ok = &{1'b0, read_address[1:0]};

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign overflow = overflow_q;
  assign misalign = misalign_q;

  // Decode the incoming store into a lane-placed entry and an alignment verdict.
  always_comb begin
    st_ok   = 1'b0;
    st.addr = write_address[31:2];
    st.mask = 4'b0000;
    st.data = '0;
    case (size)
      2'b00: begin
        st_ok   = 1'b1;
        st.mask = 4'b0001 << write_address[1:0];
        st.data = {4{DATA_out[7:0]}};
      end
      2'b01: begin
        st_ok   = ~write_address[0];
        st.mask = 4'b0011 << write_address[1:0];
        st.data = {2{DATA_out[15:0]}};
      end
      2'b10: begin
        st_ok   = (write_address[1:0] == 2'b00);
        st.mask = 4'b1111;
        st.data = DATA_out;
      end
      default: st_ok = 1'b0;
    endcase
    // Zero the unused lanes so buffered data is clean.
    for (int k = 0; k < 4; k++)
      if (!st.mask[k]) st.data[8*k +: 8] = 8'h00;
  end

  // Loads win the port; otherwise the head entry drains.
  always_comb begin
    pop       = ~read & ~empty;
    push      = write & st_ok & (~full | pop);
    mem_en    = read | ~empty;
    mem_we    = pop;
    mem_addr  = read ? read_address[31:2] : ent_q[head_q].addr;
    mem_be    = pop ? ent_q[head_q].mask : 4'b0000;
    mem_wdata = pop ? ent_q[head_q].data : 32'h0;
  end

  // FIFO pointer/count update and sticky error flags.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) ent_d[i] = ent_q[i];
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q | (write & st_ok & ~push);
    misalign_d = misalign_q | (write & ~st_ok);
    if (push) begin
      ent_d[tail_q] = st;
      tail_d        = tail_q + 1'b1;
    end
    if (pop) head_d = head_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  // Forwarding snapshot: walk oldest to youngest so later matches overwrite,
  // then let the same-cycle store (logically older than the load) win last.
  always_comb begin
    fwd_mask_d = fwd_mask_q;
    fwd_data_d = fwd_data_q;
    idx        = head_q;
    if (read) begin
      fwd_mask_d = 4'b0000;
      fwd_data_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
        idx = head_q + PW'(i);
        if (CW'(i) < count_q && ent_q[idx].addr == read_address[31:2])
          for (int k = 0; k < 4; k++)
            if (ent_q[idx].mask[k]) begin
              fwd_mask_d[k]         = 1'b1;
              fwd_data_d[8*k +: 8]  = ent_q[idx].data[8*k +: 8];
            end
      end
      if (push && st.addr == read_address[31:2])
        for (int k = 0; k < 4; k++)
          if (st.mask[k]) begin
            fwd_mask_d[k]        = 1'b1;
            fwd_data_d[8*k +: 8] = st.data[8*k +: 8];
          end
    end
  end

  // Load return: merge forwarded lanes over SRAM data, hold until next load.
  always_comb begin
    for (int k = 0; k < 4; k++)
      merged[8*k +: 8] = fwd_mask_q[k] ? fwd_data_q[8*k +: 8] : mem_rdata[8*k +: 8];
    DATA_in   = rd_pend_q ? merged : data_in_q;
    data_in_d = DATA_in;
    rd_pend_d = read;
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      misalign_q <= 1'b0;
      fwd_mask_q <= 4'b0000;
      fwd_data_q <= '0;
      rd_pend_q  <= 1'b0;
      data_in_q  <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      misalign_q <= misalign_d;
      fwd_mask_q <= fwd_mask_d;
      fwd_data_q <= fwd_data_d;
      rd_pend_q  <= rd_pend_d;
      data_in_q  <= data_in_d;
    end
  end

  // Entry storage; validity is tracked by count, so no reset is needed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
  end

endmodule

// File: tb/tb_arv_store_buffer.sv
// Directed bench for arv_store_buffer with a small SRAM model.
module tb_arv_store_buffer;

  logic        clk = 1'b0;
  logic        reset, write, read;
  logic [31:0] write_address, DATA_out, read_address, DATA_in;
  logic [1:0]  size;
  logic        mem_en, mem_we, empty, full, overflow, misalign;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] mem [256];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  arv_store_buffer #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .write(write), .write_address(write_address),
    .DATA_out(DATA_out), .size(size), .read(read), .read_address(read_address),
    .DATA_in(DATA_in), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .empty(empty), .full(full), .overflow(overflow), .misalign(misalign)
  );

  // SRAM model: one-cycle read latency, byte-lane writes, preloaded on reset.
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i == 128) ? 32'h11223344 : 32'h0;
      mem_rdata <= 32'h0;
    end else if (mem_en && !mem_we) begin
      mem_rdata <= mem[mem_addr[7:0]];
    end else if (mem_en && mem_we) begin
      for (int k = 0; k < 4; k++)
        if (mem_be[k]) mem[mem_addr[7:0]][8*k +: 8] <= mem_wdata[8*k +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    write = 1'b1; write_address = a; DATA_out = d; size = s;
  endtask

  task automatic ld(input logic [31:0] a);
    read = 1'b1; read_address = a;
  endtask

  task automatic idle();
    write = 1'b0; read = 1'b0;
  endtask

  initial begin
    reset = 1'b0; idle(); write_address = 0; DATA_out = 0; size = 0; read_address = 0;
    tick(); tick();
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_mis", 32'(misalign), 0);
    chk("rst_data_in", DATA_in, 0);
    reset = 1'b1; #1;
    chk("rst_mem_en", 32'(mem_en), 0);

    // Word store then drain in the idle cycle.
    st(32'h100, 32'hDEADBEEF, 2'b10); #1;
    chk("t1_pre_en", 32'(mem_en), 0);
    tick(); idle(); #1;
    chk("t1_we", 32'(mem_we), 1);
    chk("t1_addr", 32'(mem_addr), 32'h40);
    chk("t1_be", 32'(mem_be), 32'hF);
    chk("t1_wdata", mem_wdata, 32'hDEADBEEF);
    tick();
    chk("t1_empty", 32'(empty), 1);
    chk("t1_idle_en", 32'(mem_en), 0);

    // Byte + half forwarding merged over SRAM data.
    ld(32'h0); st(32'h201, 32'h000000AA, 2'b00); tick();
    st(32'h202, 32'h0000BEEF, 2'b01); tick();
    write = 1'b0; ld(32'h200); #1;
    chk("t2_rd_addr", 32'(mem_addr), 32'h80);
    chk("t2_rd_we", 32'(mem_we), 0);
    chk("t2_rd_be", 32'(mem_be), 0);
    tick(); idle(); #1;
    chk("t2_data_in", DATA_in, 32'hBEEFAA44);
    chk("t2_dr0_be", 32'(mem_be), 32'h2);
    chk("t2_dr0_wd", mem_wdata, 32'h0000AA00);
    tick();
    chk("t2_dr1_be", 32'(mem_be), 32'hC);
    chk("t2_dr1_wd", mem_wdata, 32'hBEEF0000);
    chk("t2_hold", DATA_in, 32'hBEEFAA44);
    tick();
    chk("t2_empty", 32'(empty), 1);

    // Youngest store wins; same-cycle store is visible to the load.
    ld(32'h0); st(32'h300, 32'h1, 2'b10); tick();
    st(32'h300, 32'h2, 2'b10); tick();
    write = 1'b0; ld(32'h300); tick();
    chk("t3_youngest", DATA_in, 32'h2);
    ld(32'h300); st(32'h300, 32'h3, 2'b10); tick();
    idle(); #1;
    chk("t3_same_cyc", DATA_in, 32'h3);
    chk("t3_dr0", mem_wdata, 32'h1);
    tick();
    chk("t3_dr1", mem_wdata, 32'h2);
    tick();
    chk("t3_dr2", mem_wdata, 32'h3);
    tick();
    chk("t3_empty", 32'(empty), 1);

    // Overflow: fifth store dropped while reads block draining.
    ld(32'h0);
    for (int i = 0; i < 4; i++) begin
      st(32'h400 + 32'(4*i), 32'hA0 + 32'(i), 2'b10); tick();
    end
    chk("t4_full", 32'(full), 1);
    chk("t4_no_ovf", 32'(overflow), 0);
    st(32'h410, 32'hA4, 2'b10); tick();
    chk("t4_ovf", 32'(overflow), 1);
    chk("t4_full2", 32'(full), 1);
    idle(); #1;
    for (int i = 0; i < 4; i++) begin
      chk("t4_drain_addr", 32'(mem_addr), 32'h100 + 32'(i));
      chk("t4_drain_data", mem_wdata, 32'hA0 + 32'(i));
      tick();
    end
    chk("t4_empty", 32'(empty), 1);
    chk("t4_notfull", 32'(full), 0);

    // Misaligned half and word stores are dropped.
    st(32'h101, 32'h1234, 2'b01); tick();
    st(32'h102, 32'h5678, 2'b10); tick();
    idle(); #1;
    chk("t5_mis", 32'(misalign), 1);
    chk("t5_empty", 32'(empty), 1);
    chk("t5_ovf_sticky", 32'(overflow), 1);

    // Pointer wrap: fill 3, then 7 push/pop cycles, then forward across the wrap.
    ld(32'h0);
    for (int i = 0; i < 3; i++) begin
      st(32'h600, 32'hC0 + 32'(i), 2'b10); tick();
    end
    read = 1'b0;
    for (int n = 3; n < 10; n++) begin
      st(32'h600, 32'hC0 + 32'(n), 2'b10); #1;
      chk("t6_pp_data", mem_wdata, 32'hC0 + 32'(n - 3));
      chk("t6_pp_we", 32'(mem_we), 1);
      tick();
    end
    ld(32'h0); st(32'h600, 32'hCA, 2'b10); tick();
    chk("t6_full", 32'(full), 1);
    write = 1'b0; ld(32'h600); tick();
    idle(); #1;
    chk("t6_fwd_wrap", DATA_in, 32'hCA);
    chk("t6_dr0", mem_wdata, 32'hC7);
    tick();
    chk("t6_dr1", mem_wdata, 32'hC8);
    reset = 1'b0; tick();
    reset = 1'b1; #1;
    chk("t6_rst_empty", 32'(empty), 1);
    chk("t6_rst_en", 32'(mem_en), 0);
    chk("t6_rst_ovf", 32'(overflow), 0);
    chk("t6_rst_mis", 32'(misalign), 0);
    chk("t6_rst_full", 32'(full), 0);
    chk("t6_rst_data", DATA_in, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/arv_store_buffer.md
# arv_store_buffer

Posted-write store buffer between the ARV core's data port and a single-port synchronous data SRAM. Core stores enter a DEPTH-entry FIFO and drain to memory in idle cycles. Core loads always get the memory port first and return a fixed one-cycle-latency word, with byte-granular forwarding from buffered stores. The core has no stall input, so the block never back-pressures it; overflow and misalignment raise sticky error flags instead.

## Interface
- DEPTH, 4: store entries (power of two, 2..16)
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clk
- write  in  1  core store strobe, one store per asserted cycle
- write_address  in  32  store byte address
- DATA_out  in  32  store data, right-aligned
- size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as misaligned)
- read  in  1  core load strobe
- read_address  in  32  load byte address
- DATA_in  out  32  full aligned word for the load issued the previous cycle; core extracts lanes
- mem_en  out  1  SRAM access enable
- mem_we  out  1  SRAM write (valid with mem_en)
- mem_addr  out  30  SRAM word address
- mem_be  out  4  byte-lane write enables
- mem_wdata  out  32  SRAM write data
- mem_rdata  in  32  SRAM read data, valid the cycle after a read access
- empty  out  1  no buffered stores
- full  out  1  DEPTH entries held
- overflow  out  1  sticky: a store was dropped because the buffer was full
- misalign  out  1  sticky: a store was dropped because it was misaligned

## Operation
- Entry: word address [31:2], 32-bit lane-placed data, 4-bit byte mask. The FIFO uses head/tail pointers (log2 DEPTH bits, natural wrap) and a count of 0..DEPTH.
- Store accept:
  - byte: mask 0001 << a[1:0], data byte copied to that lane.
  - half: a[0] must be 0; mask 0011 << a[1:0].
  - word: a[1:0] must be 00; mask 1111.
- Misaligned store or size 11: store dropped, misalign set.
- Port arbitration, per cycle:
  - If read is asserted: mem_en=1, mem_we=0, mem_addr=read_address[31:2], mem_be=0000. No drain this cycle.
  - Else if the buffer is not empty: drive the head entry with mem_en=1, mem_we=1, mem_be=mask, mem_wdata=data, and pop the head at the clock edge.
  - Else: mem_en=0.
- Push/pop:
  - A store is accepted if count<DEPTH, or if a pop occurs in the same cycle.
  - Otherwise it is dropped and overflow is set.
  - Simultaneous push and pop leaves count unchanged.
- Forwarding at load cycle t:
  - Snapshot, for each byte lane, the youngest matching data among valid entries and the store accepted in cycle t. A store in the same cycle counts as older than the load, so it is visible.
  - A match requires an equal word address and that lane's mask bit set.
  - Register the snapshot (lane mask and data).
  - At t+1, each lane of DATA_in = the forwarded byte if its lane bit is set, else the mem_rdata byte. DATA_in holds its value until the next load.
- Sticky flags clear only on reset.

## Timing
- Reset (reset=0 at an edge): count=0, pointers=0, empty=1, full=0, overflow=0, misalign=0, DATA_in=0, forward mask=0. mem_en=0 in the first cycle after release. Buffered stores are discarded; a load in flight returns no data (DATA_in=0).
- Load latency: strobe at cycle t, DATA_in valid at t+1. Back-to-back loads are fully pipelined.
- Store drain latency: earliest the cycle after acceptance; delayed for each cycle read is asserted.
- Memory outputs and DATA_in merge are combinational from registered state plus the current read/read_address. empty/full come directly from count.
- Wrap-around: pointers roll from DEPTH-1 to 0; forwarding age order follows the logical order from head to tail, not the physical index.

## Test plan
- Reset, then word store 0xDEADBEEF at 0x100, idle cycle -> mem_we=1, mem_addr=0x40, mem_be=1111, mem_wdata=0xDEADBEEF; empty=1 afterwards.
- Memory word 0x11223344 at 0x200; byte store 0xAA to 0x201 and half store 0xBEEF to 0x202, with read held high so nothing drains; load 0x200 -> DATA_in=0xBEEFAA44.
- Two word stores to 0x300 (0x1, then 0x2), then a load of 0x300 -> DATA_in=0x00000002 (youngest wins); same-cycle store 0x3 plus load of 0x300 -> 0x00000003.
- DEPTH=4, reads held high, 5 word stores -> full=1 after the 4th; the 5th is dropped and overflow=1; release read -> 4 drains in order, then empty=1.
- Half store to 0x101 and word store to 0x102 -> both dropped, misalign=1, empty stays 1.
- Fill 3 entries, drain through 7 push/pop cycles so the pointers wrap, then check drain order and forwarding; assert reset mid-drain -> empty=1, mem_en=0 in the next cycle, all flags=0.
